// File: rtl/traffic_phase_scheduler.sv
// Two-road signalised intersection controller with pedestrian walk phases.
// Road 1 rests in green until road 2 or a pedestrian asks for service.
module traffic_phase_scheduler #(
  parameter int unsigned CLK_HZ   = 1000000,
  parameter int unsigned GREEN_S  = 30,
  parameter int unsigned YELLOW_S = 5,
  parameter int unsigned ALLRED_S = 2,
  parameter int unsigned WALK_S   = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ped1_req,
  input  logic       ped2_req,
  input  logic       veh2,
  output logic       r1,
  output logic       y1,
  output logic       g1,
  output logic       r2,
  output logic       y2,
  output logic       g2,
  output logic       walk1,
  output logic       walk2,
  output logic       tick,
  output logic [2:0] phase
);

  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned MAX_S = (GREEN_S > YELLOW_S)
                                ? ((GREEN_S > ALLRED_S) ? GREEN_S : ALLRED_S)
                                : ((YELLOW_S > ALLRED_S) ? YELLOW_S : ALLRED_S);
  localparam int unsigned SEC_W = (MAX_S > 1) ? $clog2(MAX_S) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
  // sec value at the tick that completes WALK_S seconds of a green
  localparam logic [SEC_W-1:0] WALK_END = SEC_W'(GREEN_S - WALK_S);

  typedef enum logic [2:0] {
    G1  = 3'd0,
    Y1  = 3'd1,
    AR1 = 3'd2,
    G2  = 3'd3,
    Y2  = 3'd4,
    AR2 = 3'd5
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [PRE_W-1:0] prescaler;
  logic [SEC_W-1:0] sec;
  logic             ped1_pend;
  logic             ped2_pend;
  logic             expire;
  logic             enter_g1;
  logic             enter_g2;
  logic             walk_done;

  function automatic logic [SEC_W-1:0] load_val(input state_t s);
    case (s)
      G1, G2:  load_val = SEC_W'(GREEN_S - 1);
      Y1, Y2:  load_val = SEC_W'(YELLOW_S - 1);
      default: load_val = SEC_W'(ALLRED_S - 1);
    endcase
  endfunction

  assign tick      = (prescaler == PRE_LAST);
  assign expire    = tick && (sec == '0);
  assign enter_g1  = (state_n == G1) && (state != G1);
  assign enter_g2  = (state_n == G2) && (state != G2);
  assign walk_done = tick && (sec <= WALK_END);
  assign phase     = state;

  always_comb begin
    state_n = state;
    case (state)
      G1:  if (expire && (veh2 || ped1_pend || ped2_pend)) state_n = Y1;
      Y1:  if (expire) state_n = AR1;
      AR1: if (expire) state_n = G2;
      G2:  if (expire) state_n = Y2;
      Y2:  if (expire) state_n = AR2;
      AR2: if (expire) state_n = G1;
      default: state_n = G1;
    endcase
  end

  // Resting G1 keeps sec at 0 so every later tick re-evaluates the exit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= G1;
      sec       <= SEC_W'(GREEN_S - 1);
      prescaler <= '0;
    end else begin
      state     <= state_n;
      prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      if (state_n != state) begin
        sec <= load_val(state_n);
      end else if (tick && (sec != '0)) begin
        sec <= sec - SEC_W'(1);
      end
    end
  end

  // A request seen on the green-entry cycle is served directly, not latched
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      walk1     <= 1'b0;
      walk2     <= 1'b0;
      ped1_pend <= 1'b0;
      ped2_pend <= 1'b0;
    end else begin
      if (enter_g1) begin
        walk1 <= ped1_pend || ped1_req;
      end else if ((state_n != G1) || walk_done) begin
        walk1 <= 1'b0;
      end

      if (enter_g2) begin
        walk2 <= ped2_pend || ped2_req;
      end else if ((state_n != G2) || walk_done) begin
        walk2 <= 1'b0;
      end

      if (enter_g1 && (ped1_pend || ped1_req)) begin
        ped1_pend <= 1'b0;
      end else if (ped1_req && !walk1) begin
        ped1_pend <= 1'b1;
      end

      if (enter_g2 && (ped2_pend || ped2_req)) begin
        ped2_pend <= 1'b0;
      end else if (ped2_req && !walk2) begin
        ped2_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    r1 = 1'b0;
    y1 = 1'b0;
    g1 = 1'b0;
    r2 = 1'b0;
    y2 = 1'b0;
    g2 = 1'b0;
    case (state)
      G1:      begin g1 = 1'b1; r2 = 1'b1; end
      Y1:      begin y1 = 1'b1; r2 = 1'b1; end
      G2:      begin r1 = 1'b1; g2 = 1'b1; end
      Y2:      begin r1 = 1'b1; y2 = 1'b1; end
      default: begin r1 = 1'b1; r2 = 1'b1; end
    endcase
  end

endmodule
